// File: rtl/glitch_sweeper_pkg.sv
// glitch_pkg: shared FSM encoding, default widths and wait lengths for the glitch sweeper
package glitch_pkg;
  localparam int DEF_W = 32;
  localparam int DEF_RESET_CYCLES = 1000;
  localparam int DEF_GLITCH_TIMEOUT = 1 << 24;
  localparam int DEF_SETTLE_CYCLES = 100000;
  localparam int TW = 32;
  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_ARM,
    S_WAIT_GLITCH,
    S_SETTLE,
    S_NEXT,
    S_DONE
  } state_t;
endpackage

// File: rtl/glitch_sweeper_if.sv
// glitch_sweeper_if: control, sweep bounds, target handshake and status of the glitch sweeper
interface glitch_sweeper_if
  import glitch_pkg::*;
#(
  parameter int W = DEF_W
);
  logic start;
  logic abort;
  logic [W-1:0] ofs_start;
  logic [W-1:0] ofs_stop;
  logic [W-1:0] ofs_step;
  logic [W-1:0] dur_start;
  logic [W-1:0] dur_stop;
  logic [W-1:0] dur_step;
  logic glitch_n;
  logic success;
  logic target_reset;
  logic start_offset_counter;
  logic [W-1:0] offset;
  logic [W-1:0] duration;
  logic busy;
  logic sweep_done;
  logic hit;
  logic [W-1:0] hit_offset;
  logic [W-1:0] hit_duration;
  logic [31:0] attempt_count;
  modport master (
    output start, abort, ofs_start, ofs_stop, ofs_step, dur_start, dur_stop, dur_step,
    output glitch_n, success,
    input target_reset, start_offset_counter, offset, duration, busy, sweep_done,
    input hit, hit_offset, hit_duration, attempt_count
  );
  modport slave (
    input start, abort, ofs_start, ofs_stop, ofs_step, dur_start, dur_stop, dur_step,
    input glitch_n, success,
    output target_reset, start_offset_counter, offset, duration, busy, sweep_done,
    output hit, hit_offset, hit_duration, attempt_count
  );
endinterface

// File: rtl/glitch_sweeper_cycle_timer.sv
// cycle_timer: loadable down-counter that flags expiry when it reaches zero
module cycle_timer
  import glitch_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] val,
  output logic          expired
);
  logic [TW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= val;
    else if (cnt != '0) cnt <= cnt - TW'(1);
  end
  assign expired = cnt == '0;
endmodule

// File: rtl/glitch_sweeper.sv
// glitch_sweeper: sweeps offset x duration glitch attempts, resetting and arming the target each time
module glitch_sweeper
  import glitch_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int GLITCH_TIMEOUT = DEF_GLITCH_TIMEOUT,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input logic clk,
  input logic rst,
  glitch_sweeper_if.slave bus
);
  state_t state, state_n;
  logic [W-1:0] ofs_start_l, ofs_stop_l, ofs_step_l, dur_start_l, dur_stop_l, dur_step_l;
  logic [W-1:0] offset_r, duration_r, hit_offset_r, hit_duration_r;
  logic [31:0] attempt_count_r;
  logic hit_r, seen_low, t_load, t_exp, ofs_over, dur_over, glitch_seen;
  logic [TW-1:0] t_val;
  cycle_timer u_timer (
    .clk(clk),
    .rst(rst),
    .load(t_load),
    .val(t_val),
    .expired(t_exp)
  );
  // compare at W+1 bits so a step past the top of the range cannot wrap back in
  assign ofs_over = ofs_step_l == '0 || ({1'b0, offset_r} + {1'b0, ofs_step_l}) > {1'b0, ofs_stop_l};
  assign dur_over = dur_step_l == '0 || ({1'b0, duration_r} + {1'b0, dur_step_l}) > {1'b0, dur_stop_l};
  assign glitch_seen = seen_low && bus.glitch_n;
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    t_load = 1'b0;
    t_val = '0;
    case (state)
      S_IDLE: if (bus.start) begin
        state_n = S_RESET;
        t_load = 1'b1;
        t_val = TW'(RESET_CYCLES - 1);
      end
      S_RESET: state_n = t_exp ? S_ARM : S_RESET;
      S_ARM: begin
        state_n = S_WAIT_GLITCH;
        t_load = 1'b1;
        t_val = TW'(GLITCH_TIMEOUT - 1);
      end
      S_WAIT_GLITCH: if (glitch_seen) begin
        state_n = S_SETTLE;
        t_load = 1'b1;
        t_val = TW'(SETTLE_CYCLES - 1);
      end else if (t_exp) state_n = S_NEXT;
      S_SETTLE: state_n = bus.success ? S_DONE : t_exp ? S_NEXT : S_SETTLE;
      S_NEXT: if (ofs_over && dur_over) state_n = S_DONE;
      else begin
        state_n = S_RESET;
        t_load = 1'b1;
        t_val = TW'(RESET_CYCLES - 1);
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (bus.abort && state != S_IDLE) begin
      state_n = S_IDLE;
      t_load = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {ofs_start_l, ofs_stop_l, ofs_step_l, dur_start_l, dur_stop_l, dur_step_l} <= '0;
      {offset_r, duration_r, hit_offset_r, hit_duration_r} <= '0;
      attempt_count_r <= '0;
      hit_r <= 1'b0;
      seen_low <= 1'b0;
    end else begin
      if (state == S_IDLE && bus.start) begin
        ofs_start_l <= bus.ofs_start;
        ofs_stop_l <= bus.ofs_stop;
        ofs_step_l <= bus.ofs_step;
        dur_start_l <= bus.dur_start;
        dur_stop_l <= bus.dur_stop;
        dur_step_l <= bus.dur_step;
        offset_r <= bus.ofs_start;
        duration_r <= bus.dur_start;
        attempt_count_r <= '0;
        hit_r <= 1'b0;
      end
      if (state == S_ARM) seen_low <= 1'b0;
      else if (state == S_WAIT_GLITCH && !bus.glitch_n) seen_low <= 1'b1;
      if (!bus.abort && state == S_SETTLE && bus.success) begin
        hit_r <= 1'b1;
        hit_offset_r <= offset_r;
        hit_duration_r <= duration_r;
      end
      if (!bus.abort && state == S_NEXT) begin
        attempt_count_r <= attempt_count_r + 32'(attempt_count_r != '1);
        offset_r <= ofs_over ? ofs_start_l : offset_r + ofs_step_l;
        if (ofs_over && !dur_over) duration_r <= duration_r + dur_step_l;
      end
    end
  end
  assign bus.target_reset = state == S_RESET;
  assign bus.start_offset_counter = state == S_ARM;
  assign bus.busy = state != S_IDLE;
  assign bus.sweep_done = state == S_DONE;
  assign bus.offset = offset_r;
  assign bus.duration = duration_r;
  assign bus.hit = hit_r;
  assign bus.hit_offset = hit_offset_r;
  assign bus.hit_duration = hit_duration_r;
  assign bus.attempt_count = attempt_count_r;
endmodule

// File: tb/tb_glitch_sweeper.sv
// tb_glitch_sweeper: table-driven sweeps with an attempt scoreboard plus reset corner sequences
module tb_glitch_sweeper;
  localparam int W = 8;
  typedef struct {
    logic [W-1:0] os, oe, op, ds, de, dp;
    bit glitch;
    int succ_at;
    int abort_at;
    int e_cnt;
    bit e_hit;
    logic [W-1:0] e_ho, e_hd;
    int e_done;
  } vec_t;
  typedef struct {
    longint o;
    longint d;
  } att_t;
  logic clk = 0;
  logic rst = 1;
  int n_vec = 0;
  int n_fail = 0;
  att_t q[$];
  vec_t vecs[6];
  glitch_sweeper_if #(.W(W)) b ();
  glitch_sweeper #(
    .W(W),
    .RESET_CYCLES(4),
    .GLITCH_TIMEOUT(50),
    .SETTLE_CYCLES(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(b)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_target_reset"}, b.target_reset, 0);
    chk({tag, "_start_ofs_cnt"}, b.start_offset_counter, 0);
    chk({tag, "_busy"}, b.busy, 0);
    chk({tag, "_sweep_done"}, b.sweep_done, 0);
    chk({tag, "_hit"}, b.hit, 0);
    chk({tag, "_offset"}, b.offset, 0);
    chk({tag, "_duration"}, b.duration, 0);
    chk({tag, "_hit_offset"}, b.hit_offset, 0);
    chk({tag, "_hit_duration"}, b.hit_duration, 0);
    chk({tag, "_attempt_count"}, b.attempt_count, 0);
  endtask
  task automatic model(input vec_t v);
    longint o = v.os, d = v.ds;
    int lim = v.succ_at >= 0 ? v.succ_at + 1 : v.abort_at >= 0 ? v.abort_at : 1000;
    q.delete();
    for (int i = 0; i < 64; i++) begin
      if (i < lim) q.push_back('{o, d});
      if (v.op == 0 || o + v.op > v.oe) begin
        o = v.os;
        if (v.dp == 0 || d + v.dp > v.de) break;
        d += v.dp;
      end else o += v.op;
    end
  endtask
  task automatic start_sweep(input vec_t v);
    b.ofs_start = v.os; b.ofs_stop = v.oe; b.ofs_step = v.op;
    b.dur_start = v.ds; b.dur_stop = v.de; b.dur_step = v.dp;
    b.start = 1;
    @(posedge clk); #1;
    b.start = 0;
    {b.ofs_start, b.ofs_stop, b.ofs_step} = 24'($urandom);
    {b.dur_start, b.dur_stop, b.dur_step} = 24'($urandom);
  endtask
  task automatic run_vec(input int idx, input vec_t v);
    int arms = 0, since = -1, done_cnt = 0, aborted = 0;
    bit fin = 0;
    att_t e;
    model(v);
    start_sweep(v);
    chk($sformatf("v%0d_busy_after_start", idx), b.busy, 1);
    for (int c = 0; c < 3000 && !fin; c++) begin
      @(posedge clk); #1;
      if (b.start_offset_counter) begin
        arms++;
        since = 0;
        if (q.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL v%0d_extra_attempt: got (%0d,%0d) want none", idx, b.offset, b.duration);
        end else begin
          e = q.pop_front();
          chk($sformatf("v%0d_arm%0d_offset", idx, arms), b.offset, e.o);
          chk($sformatf("v%0d_arm%0d_duration", idx, arms), b.duration, e.d);
        end
      end else if (since >= 0) since++;
      if (b.sweep_done) done_cnt++;
      if (aborted == 1) begin
        chk($sformatf("v%0d_abort_busy", idx), b.busy, 0);
        chk($sformatf("v%0d_abort_target_reset", idx), b.target_reset, 0);
        aborted = 2;
      end
      b.glitch_n = !(v.glitch && since >= 5 && since <= 7);
      b.success = v.succ_at == arms - 1 && since == 11;
      b.abort = v.abort_at >= 0 && aborted == 0 && arms == v.abort_at && b.target_reset;
      if (b.abort) aborted = 1;
      if (!b.busy) fin = 1;
    end
    b.glitch_n = 1; b.success = 0; b.abort = 0;
    chk($sformatf("v%0d_sweep_finished", idx), fin, 1);
    chk($sformatf("v%0d_attempt_count", idx), b.attempt_count, v.e_cnt);
    chk($sformatf("v%0d_hit", idx), b.hit, v.e_hit);
    if (v.e_hit) begin
      chk($sformatf("v%0d_hit_offset", idx), b.hit_offset, v.e_ho);
      chk($sformatf("v%0d_hit_duration", idx), b.hit_duration, v.e_hd);
    end
    chk($sformatf("v%0d_sweep_done_pulses", idx), done_cnt, v.e_done);
    chk($sformatf("v%0d_missing_attempts", idx), q.size(), 0);
  endtask
  initial begin
    b.start = 1; b.abort = 1; b.glitch_n = 1; b.success = 0;
    {b.ofs_start, b.ofs_stop, b.ofs_step, b.dur_start, b.dur_stop, b.dur_step} = '0;
    vecs[0] = '{0, 4, 2, 1, 2, 1, 1, -1, -1, 6, 0, 0, 0, 1};
    vecs[1] = '{0, 4, 2, 1, 2, 1, 1, 4, -1, 4, 1, 2, 2, 1};
    vecs[2] = '{0, 2, 2, 1, 1, 1, 0, -1, -1, 2, 0, 0, 0, 1};
    vecs[3] = '{0, 4, 2, 1, 2, 1, 1, -1, 2, 2, 0, 0, 0, 0};
    vecs[4] = '{7, 9, 0, 5, 3, 1, 1, -1, -1, 1, 0, 0, 0, 1};
    vecs[5] = '{250, 255, 3, 254, 255, 1, 1, -1, -1, 4, 0, 0, 0, 1};
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("rst_over_start");
    rst = 0; b.start = 0; b.abort = 0;
    @(posedge clk); #1;
    chk("idle_stays_idle", b.busy, 0);
    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);
    begin
      int since = -1;
      bit hit_rst = 0;
      start_sweep(vecs[0]);
      for (int c = 0; c < 200 && !hit_rst; c++) begin
        @(posedge clk); #1;
        if (b.start_offset_counter) since = 0;
        else if (since >= 0) since++;
        b.glitch_n = !(since >= 5 && since <= 7);
        if (since == 12) begin
          rst = 1; b.success = 1; hit_rst = 1;
        end
      end
      chk("settle_reached", hit_rst, 1);
      @(posedge clk); #1;
      chk_all_zero("rst_mid_settle");
      rst = 0; b.success = 0; b.glitch_n = 1;
      @(posedge clk); #1;
      chk("post_rst_hit", b.hit, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/glitch_sweeper.md
GLITCH_SWEEPER -- requirements
Module: glitch_sweeper

Interface
REQ-001 Parameter W, default 32: width of the offset, duration and step values.
REQ-002 Parameter RESET_CYCLES, default 1000: number of sys-clock cycles that target_reset is held per attempt.
REQ-003 Parameter GLITCH_TIMEOUT, default 2^24: maximum number of cycles spent waiting for a glitch window to complete.
REQ-004 Parameter SETTLE_CYCLES, default 100000: length, in cycles, of the post-glitch window in which success is observed.
REQ-005 clk  in  1  system clock; one clock domain only.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 start  in  1  single-cycle sweep request; honoured only in IDLE.
REQ-008 abort  in  1  stops the sweep immediately.
REQ-009 ofs_start, ofs_stop, ofs_step  in  W each  offset sweep bounds and increment.
REQ-010 dur_start, dur_stop, dur_step  in  W each  duration sweep bounds and increment.
REQ-011 glitch_n  in  1  active-low glitch window from the duration counter.
REQ-012 success  in  1  level from the target-response detector; high means the glitch worked.
REQ-013 target_reset  out  1  reset request to the resetter, offset counter and duration counter.
REQ-014 start_offset_counter  out  1  single-cycle arm pulse to the offset counter.
REQ-015 offset, duration  out  W each  current attempt parameters.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 sweep_done  out  1  single-cycle pulse when a sweep completes without abort.
REQ-018 hit  out  1  sticky flag; high when a successful attempt was found.
REQ-019 hit_offset, hit_duration  out  W each  parameters of the successful attempt.
REQ-020 attempt_count  out  32  number of completed attempts; saturates at all-ones.

Function
REQ-021 FSM states: IDLE, RESET, ARM, WAIT_GLITCH, SETTLE, NEXT, DONE.
REQ-022 IDLE + start: sweep setup, then -> RESET.
- Latch all six bounds.
- offset <= ofs_start; duration <= dur_start.
- attempt_count <= 0; hit <= 0.
REQ-023 RESET: target_reset = 1 for exactly RESET_CYCLES cycles, then -> ARM; target_reset = 0 in every other state.
REQ-024 ARM: start_offset_counter = 1 for exactly one cycle, then -> WAIT_GLITCH.
REQ-025 WAIT_GLITCH: -> SETTLE on the first cycle glitch_n is sampled high after having been sampled low.
- If GLITCH_TIMEOUT cycles elapse first, -> NEXT with no hit.
REQ-026 SETTLE: runs for SETTLE_CYCLES cycles.
- Any cycle with success = 1: hit <= 1, hit_offset/hit_duration <= current values, -> DONE.
- Expiry without success: -> NEXT.
REQ-027 NEXT (one cycle): attempt_count increments, then the sweep advances.
- Offset axis: if offset + ofs_step > ofs_stop, evaluated at W+1 bits with no wrap, then offset <= ofs_start and duration advances by dur_step; otherwise offset += ofs_step.
- Duration axis: if duration + dur_step > dur_stop, also at W+1 bits, -> DONE; otherwise -> RESET.
REQ-028 A step of 0 means that axis takes a single value: it is treated as overflowing immediately.
REQ-029 start > stop on either axis yields exactly one attempt at the start values.
REQ-030 DONE: sweep_done = 1 for one cycle, then -> IDLE.
REQ-031 abort in any non-IDLE state: -> IDLE on the next edge.
- target_reset deasserts; sweep_done is not pulsed.
- hit and attempt_count keep their values.
REQ-032 abort takes priority over success and over timer expiry in the same cycle.
REQ-033 start while busy is ignored; a latched bound changing mid-sweep does not affect the current sweep.
REQ-034 offset and duration stay stable from ARM through SETTLE.

Reset
REQ-035 rst forces state IDLE.
REQ-036 rst clears every output to 0: target_reset, start_offset_counter, busy, sweep_done, hit, offset, duration, hit_offset, hit_duration, attempt_count.
REQ-037 rst clears all internal timers and the glitch_n-seen-low flag.
REQ-038 rst overrides start and abort in the same cycle.

Structure
REQ-039 Shared package glitch_pkg holds the FSM state encoding, the default W, and the RESET_CYCLES, GLITCH_TIMEOUT and SETTLE_CYCLES defaults.
REQ-040 One sub-module, cycle_timer, provides a loadable down-counter with an expired flag, with clk/rst; it is reused for the RESET, WAIT_GLITCH and SETTLE waits.

Verification (bench sets RESET_CYCLES=4, GLITCH_TIMEOUT=50, SETTLE_CYCLES=10)
REQ-041 Sweep with glitch_n low for 3 cycles 5 cycles after each arm.
- Stimulus: ofs 0..4 step 2, dur 1..2 step 1, success never high.
- Response: 6 attempts in order (0,1)(2,1)(4,1)(0,2)(2,2)(4,2); one sweep_done; attempt_count=6; hit=0.
REQ-042 Same sweep, success pulsed during SETTLE of attempt (2,2).
- Response: hit=1, hit_offset=2, hit_duration=2, attempt_count=4, sweep_done pulsed.
REQ-043 glitch_n held high throughout.
- Response: each attempt times out after 50 cycles; the sweep still completes; sweep_done pulsed.
REQ-044 abort asserted during RESET of attempt 3.
- Response: busy=0 and target_reset=0 next cycle; no sweep_done; attempt_count=2.
REQ-045 ofs_step=0, dur_start=5 > dur_stop=3.
- Response: exactly 1 attempt, at offset=ofs_start, duration=5.
REQ-046 rst asserted mid-SETTLE with success=1 in the same cycle.
- Response: all outputs 0 next cycle; no hit.
